// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared types and constants for the conv_acc pass sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Idle cycles between passes so conv_acc can turn its accumulators around
    localparam int GAP_CYCLES = 1;

endpackage
`default_nettype wire

// File: rtl/conv_acc_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_acc_sched_if
// Description : Command, conv_acc control and status bundle of the scheduler.
//               CONV_ACC_SCHED_PERF_EN adds the perf counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_acc_sched_if #(
    parameter int AW = 8,
    parameter int SW = 11,
    parameter int KW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [SW-1:0] cmd_size;
    logic [KW-1:0] cmd_nk;
    logic [AW-1:0] cmd_base;
    logic          acc_start;
    logic          acc_first_k;
    logic          acc_last_k;
    logic [SW-1:0] acc_size;
    logic [AW-1:0] acc_base2;
    logic          acc_m_valid;
    logic          acc_s_valid;
    logic          feed_en;
    logic [KW-1:0] pass_idx;
    logic          busy;
    logic          done;
    logic          err;
`ifdef CONV_ACC_SCHED_PERF_EN
    logic [31:0]   perf_cycles;
    logic [KW-1:0] perf_passes;

    modport master (
        output cmd_valid, cmd_size, cmd_nk, cmd_base, acc_m_valid, acc_s_valid,
        input  cmd_ready, acc_start, acc_first_k, acc_last_k, acc_size, acc_base2,
        input  feed_en, pass_idx, busy, done, err, perf_cycles, perf_passes
    );
    modport slave (
        input  cmd_valid, cmd_size, cmd_nk, cmd_base, acc_m_valid, acc_s_valid,
        output cmd_ready, acc_start, acc_first_k, acc_last_k, acc_size, acc_base2,
        output feed_en, pass_idx, busy, done, err, perf_cycles, perf_passes
    );
`else
    modport master (
        output cmd_valid, cmd_size, cmd_nk, cmd_base, acc_m_valid, acc_s_valid,
        input  cmd_ready, acc_start, acc_first_k, acc_last_k, acc_size, acc_base2,
        input  feed_en, pass_idx, busy, done, err
    );
    modport slave (
        input  cmd_valid, cmd_size, cmd_nk, cmd_base, acc_m_valid, acc_s_valid,
        output cmd_ready, acc_start, acc_first_k, acc_last_k, acc_size, acc_base2,
        output feed_en, pass_idx, busy, done, err
    );
`endif
endinterface
`default_nettype wire

// File: rtl/conv_acc_beat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : conv_acc_beat_cnt
// Description : Loadable W-bit beat counter; wraps to 0 on an enabled beat at term.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_acc_beat_cnt #(
    parameter int W = 11
) (
    input  wire         clk,
    input  wire         rst,
    input  wire         load,
    input  wire [W-1:0] load_val,
    input  wire         en,
    input  wire [W-1:0] term,
    output logic        at_term
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en) begin
            r_cnt <= at_term ? '0 : r_cnt + W'(1);
        end
    end

    assign at_term = (r_cnt == term);

endmodule
`default_nettype wire

// File: rtl/conv_acc_sched.sv
`default_nettype none
// ============================================================================
// Module      : conv_acc_sched
// Description : Pass sequencer for conv_acc: one start per input-channel pass,
//               beat counting for pass completion. Option: CONV_ACC_SCHED_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_acc_sched
    import conv_pkg::*;
#(
    parameter int AW = 8,
    parameter int SW = 11,
    parameter int KW = 8
) (
    input wire              clk,
    input wire              rst,
    conv_acc_sched_if.slave bus
);

    state_t        r_state;
    state_t        w_next;
    logic          r_first_k;
    logic          r_last_k;
    logic [SW-1:0] r_acc_size;
    logic [AW-1:0] r_acc_base2;
    logic [KW-1:0] r_pass_idx;
    logic [KW-1:0] r_nk;
    logic [3:0]    r_gap_cnt;
    logic          r_err;

    logic          w_accept;
    logic          w_size_zero;
    logic [KW-1:0] w_nk_eff;
    logic          w_beat;
    logic          w_run_beat;
    logic          w_at_term;
    logic          w_pass_end;
    logic          w_gap_end;
    logic [KW-1:0] w_pass_nxt;

    assign w_accept    = bus.cmd_valid && (r_state == IDLE);
    assign w_size_zero = (bus.cmd_size == '0);
    assign w_nk_eff    = (bus.cmd_nk == '0) ? KW'(1) : bus.cmd_nk;
    // Only the valid matching the pass type counts; the other is ignored
    assign w_beat      = r_last_k ? bus.acc_s_valid : bus.acc_m_valid;
    assign w_run_beat  = (r_state == RUN) && w_beat;
    assign w_pass_end  = w_run_beat && w_at_term;
    assign w_gap_end   = (r_gap_cnt == 4'(GAP_CYCLES - 1));
    assign w_pass_nxt  = r_pass_idx + KW'(1);

    conv_acc_beat_cnt #(
        .W (SW)
    ) u_beat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (r_state != RUN),
        .load_val ('0),
        .en       (w_run_beat),
        .term     (r_acc_size - SW'(1)),
        .at_term  (w_at_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_size_zero ? DONE : START;
            START:   w_next = RUN;
            RUN:     if (w_pass_end) w_next = r_last_k ? DONE : GAP;
            GAP:     if (w_gap_end) w_next = START;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.acc_start = 1'b0;
        bus.feed_en   = 1'b0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        case (r_state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
            end
            START:   bus.acc_start = 1'b1;
            RUN:     bus.feed_en   = 1'b1;
            DONE:    bus.done      = 1'b1;
            default: ;
        endcase
    end

    // Pass descriptors only move on entry to START so conv_acc sees them stable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nk        <= '0;
            r_pass_idx  <= '0;
            r_first_k   <= 1'b0;
            r_last_k    <= 1'b0;
            r_acc_size  <= '0;
            r_acc_base2 <= '0;
        end else if ((r_state == IDLE) && (w_next == START)) begin
            r_nk        <= w_nk_eff;
            r_pass_idx  <= '0;
            r_first_k   <= 1'b1;
            r_last_k    <= (w_nk_eff == KW'(1));
            r_acc_size  <= bus.cmd_size;
            r_acc_base2 <= bus.cmd_base;
        end else if ((r_state == GAP) && (w_next == START)) begin
            r_pass_idx  <= w_pass_nxt;
            r_first_k   <= 1'b0;
            r_last_k    <= (w_pass_nxt == r_nk - KW'(1));
        end else if (w_next == IDLE) begin
            r_nk        <= '0;
            r_pass_idx  <= '0;
            r_first_k   <= 1'b0;
            r_last_k    <= 1'b0;
            r_acc_size  <= '0;
            r_acc_base2 <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != GAP)) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((bus.acc_m_valid || bus.acc_s_valid) && (r_state != RUN)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.acc_first_k = r_first_k;
    assign bus.acc_last_k  = r_last_k;
    assign bus.acc_size    = r_acc_size;
    assign bus.acc_base2   = r_acc_base2;
    assign bus.pass_idx    = r_pass_idx;
    assign bus.err         = r_err;

`ifdef CONV_ACC_SCHED_PERF_EN
    logic [31:0]   r_perf_cycles;
    logic [KW-1:0] r_perf_passes;

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_perf_cycles <= '0;
            r_perf_passes <= '0;
        end else begin
            if ((r_state != IDLE) && (r_perf_cycles != '1)) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if (w_pass_end && (r_perf_passes != '1)) begin
                r_perf_passes <= r_perf_passes + KW'(1);
            end
        end
    end

    assign bus.perf_cycles = r_perf_cycles;
    assign bus.perf_passes = r_perf_passes;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_acc_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_acc_sched
// Description : Self-checking bench for conv_acc_sched with event-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_acc_sched;

    localparam int AW    = 8;
    localparam int SW    = 11;
    localparam int KW    = 8;
    localparam int LIMIT = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    conv_acc_sched_if #(.AW(AW), .SW(SW), .KW(KW)) bus ();

    conv_acc_sched #(.AW(AW), .SW(SW), .KW(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input bit exp_err);
        chk({tag, "/cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "/busy"}, bus.busy, 0);
        chk({tag, "/done"}, bus.done, 0);
        chk({tag, "/acc_start"}, bus.acc_start, 0);
        chk({tag, "/feed_en"}, bus.feed_en, 0);
        chk({tag, "/first_k"}, bus.acc_first_k, 0);
        chk({tag, "/last_k"}, bus.acc_last_k, 0);
        chk({tag, "/acc_size"}, bus.acc_size, 0);
        chk({tag, "/acc_base2"}, bus.acc_base2, 0);
        chk({tag, "/pass_idx"}, bus.pass_idx, 0);
        chk({tag, "/err"}, bus.err, exp_err);
    endtask

    // One command from accept to the idle cycle after done. Expected timing is
    // derived from the beats the bench itself chose to drive.
    task automatic do_cmd(input string tag, input int size, input int nk, input int base,
                          input bit hold_next, input int next_size, input bit exp_err);
        int nk_eff, t, pass, beats, last_beat, done_at, n_start;
        int feed_bad, hold_bad, ready_bad, busy_cnt;
        bit running, last_pass;
        nk_eff = (nk == 0) ? 1 : nk;
        chk({tag, "/ready_before"}, bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_size  = SW'(size);
        bus.cmd_nk    = KW'(nk);
        bus.cmd_base  = AW'(base);
        tick();
        if (hold_next) bus.cmd_size = SW'(next_size);
        else bus.cmd_valid = 1'b0;
        t = 1; pass = 0; beats = 0; last_beat = -1; done_at = -1; n_start = 0;
        feed_bad = 0; hold_bad = 0; ready_bad = 0; busy_cnt = 0; running = 1'b0;
        while ((t < LIMIT) && (done_at < 0)) begin
            bus.acc_m_valid = 1'b0;
            bus.acc_s_valid = 1'b0;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.cmd_ready !== 1'b0) ready_bad++;
            if (bus.feed_en !== running) feed_bad++;
            if (bus.acc_start === 1'b1) begin
                n_start++;
                chk({tag, "/start_cycle"}, t, (pass == 0) ? 1 : last_beat + 2);
                chk({tag, "/first_k"}, bus.acc_first_k, (pass == 0));
                chk({tag, "/last_k"}, bus.acc_last_k, (pass == nk_eff - 1));
                chk({tag, "/acc_size"}, bus.acc_size, size);
                chk({tag, "/acc_base2"}, bus.acc_base2, base);
                chk({tag, "/pass_idx"}, bus.pass_idx, pass);
                running = 1'b1;
            end else if (bus.done === 1'b1) begin
                done_at = t;
                chk({tag, "/done_cycle"}, t, (size == 0) ? 1 : last_beat + 1);
            end else if (running) begin
                last_pass = (pass == nk_eff - 1);
                if ((bus.pass_idx !== KW'(pass)) || (bus.acc_size !== SW'(size)) ||
                    (bus.acc_base2 !== AW'(base)) || (bus.acc_first_k !== (pass == 0)) ||
                    (bus.acc_last_k !== last_pass)) hold_bad++;
                if ($urandom_range(0, 1) == 1) begin
                    if (last_pass) bus.acc_s_valid = 1'b1;
                    else bus.acc_m_valid = 1'b1;
                    beats++;
                    if (beats == size) begin
                        last_beat = t;
                        running   = 1'b0;
                        beats     = 0;
                        pass++;
                    end
                end
                // Noise on the valid that does not belong to this pass type
                if (last_pass) bus.acc_m_valid = 1'($urandom_range(0, 1));
                else bus.acc_s_valid = 1'($urandom_range(0, 1));
            end
            tick();
            t++;
        end
        bus.acc_m_valid = 1'b0;
        bus.acc_s_valid = 1'b0;
        chk({tag, "/done_seen"}, (done_at >= 0), 1);
        chk({tag, "/n_start"}, n_start, (size == 0) ? 0 : nk_eff);
        chk({tag, "/feed_en_window"}, feed_bad, 0);
        chk({tag, "/descriptor_hold"}, hold_bad, 0);
        chk({tag, "/ready_while_busy"}, ready_bad, 0);
        chk({tag, "/busy_cycles"}, busy_cnt, done_at);
        chk_idle({tag, "/after_done"}, exp_err);
`ifdef CONV_ACC_SCHED_PERF_EN
        chk({tag, "/perf_cycles"}, bus.perf_cycles, busy_cnt);
        chk({tag, "/perf_passes"}, bus.perf_passes, (size == 0) ? 0 : nk_eff);
`endif
    endtask

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_size    = '0;
        bus.cmd_nk      = '0;
        bus.cmd_base    = '0;
        bus.acc_m_valid = 1'b0;
        bus.acc_s_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk_idle("reset", 1'b0);
        rst = 1'b0;
        tick();

        do_cmd("single", 8, 1, 10, 1'b0, 0, 1'b0);
        do_cmd("three", 4, 3, 100, 1'b0, 0, 1'b0);
        do_cmd("size0", 0, 2, 55, 1'b0, 0, 1'b0);
        do_cmd("nk0", 3, 0, 9, 1'b0, 0, 1'b0);
        do_cmd("hold", 6, 2, 33, 1'b1, 5, 1'b0);
        do_cmd("second", 5, 1, 44, 1'b0, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            do_cmd("random", int'($urandom_range(1, 7)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 255)), 1'b0, 0, 1'b0);
            tick();
        end

        // Abandon a command after 3 of 8 beats
        bus.cmd_valid = 1'b1;
        bus.cmd_size  = SW'(8);
        bus.cmd_nk    = KW'(1);
        bus.cmd_base  = AW'(7);
        tick();
        bus.cmd_valid = 1'b0;
        chk("rst_mid/acc_start", bus.acc_start, 1);
        tick();
        bus.acc_s_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_mid/still_run", bus.feed_en, 1);
        bus.acc_s_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("rst_mid/after_rst", 1'b0);
        bus.acc_s_valid = 1'b1;
        tick();
        bus.acc_s_valid = 1'b0;
        chk("rst_mid/err_set", bus.err, 1);
        chk("rst_mid/idle_kept", bus.cmd_ready, 1);
        tick();
        do_cmd("after_rst", 5, 2, 20, 1'b0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
